// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low a..g patterns (bit 6 = a, bit 0 = g)
// and the scan FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h01;
  localparam logic [6:0] GLYPH_1 = 7'h4F;
  localparam logic [6:0] GLYPH_2 = 7'h12;
  localparam logic [6:0] GLYPH_3 = 7'h06;
  localparam logic [6:0] GLYPH_4 = 7'h4C;
  localparam logic [6:0] GLYPH_5 = 7'h24;
  localparam logic [6:0] GLYPH_6 = 7'h20;
  localparam logic [6:0] GLYPH_7 = 7'h0F;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h04;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_timer.sv
// Interval timer shared by the dwell and blank phases: counts 0..limit_i and
// raises tick_o on the final cycle, restarting from zero on the following edge.
module seg_scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_s;

  // Terminal-count detect and next count.
  always_comb begin
    tick_s = (cnt_q == limit_i);
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign tick_o = tick_s;

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner: BLANK/DRIVE scan per digit, pending/shadow
// double buffer committed only at frame boundaries, fully registered outputs.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 50_000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS*7-1:0] seg_in,
  input  logic                    load,
  input  logic                    blank_all,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][6:0] bank_t;

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  bank_t                 pend_q, pend_d;
  bank_t                 shadow_q, shadow_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fs_q, fs_d;

  bank_t                 seg_in_s;
  logic [CNT_W-1:0]      limit_s;
  logic                  tick_s;
  logic                  frame_edge_s;
  logic                  commit_s;

  assign seg_in_s = seg_in;

  // Phase length depends on which interval is currently running.
  always_comb begin
    if (state_q == DRIVE) begin
      limit_s = DWELL_LIM;
    end else begin
      limit_s = BLANK_LIM;
    end
  end

  seg_scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .limit_i (limit_s),
    .tick_o  (tick_s)
  );

  // Next-state, buffer and output computation. Outputs are derived from the
  // next state so a phase change at an edge is visible right after that edge.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    shadow_d     = shadow_q;
    seg_d        = SEG_BLANK;
    an_d         = '1;

    if (tick_s) begin
      if (state_q == BLANK) begin
        state_d = DRIVE;
      end else begin
        state_d = BLANK;
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
    end else begin
      state_d = state_q;
    end

    // Last blank cycle ahead of digit 0 is the only point shadow may change;
    // a load landing on that cycle stays pending for the next frame.
    frame_edge_s = tick_s && (state_q == BLANK) && (idx_q == '0);
    commit_s     = frame_edge_s && pend_valid_q && !load;

    if (load) begin
      pend_d       = seg_in_s;
      pend_valid_d = 1'b1;
    end else if (commit_s) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    if (commit_s) begin
      shadow_d = pend_q;
    end else begin
      shadow_d = shadow_q;
    end

    if (blank_all || (state_d == BLANK)) begin
      seg_d = SEG_BLANK;
      an_d  = '1;
    end else begin
      an_d[idx_d] = 1'b0;
      seg_d       = shadow_d[idx_d];
    end

    fs_d = frame_edge_s;
  end

  // State, buffers and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      pend_q       <= {NUM_DIGITS{SEG_BLANK}};
      shadow_q     <= {NUM_DIGITS{SEG_BLANK}};
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      fs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      shadow_q     <= shadow_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fs_q         <= fs_d;
    end
  end

  assign seg_out     = seg_q;
  assign an_n        = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: a fixed vector table for the first frame
// after reset, hand sequences for the buffering corner cases, then random traffic.
module tb_seg_scan_mux;

  localparam int N = 6;
  localparam int D = 4;
  localparam int B = 2;
  localparam int S = D + B;
  localparam int P = N * S;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load = 1'b0;
  logic             blank_all = 1'b0;
  logic [N*7-1:0]   seg_in = '0;
  logic [6:0]       seg_out;
  logic [N-1:0]     an_n;
  logic             frame_start;

  int errors = 0;
  int checks = 0;

  // Reference model: display derived from the edge count since reset.
  logic [6:0]   m_shadow [N];
  logic [6:0]   m_pend [N];
  bit           m_pv;
  int           m_k;
  logic [6:0]   e_seg;
  logic [N-1:0] e_an;
  logic         e_fs;

  typedef struct {
    logic         ld;
    logic         ba;
    logic [N-1:0] an;
    logic         fs;
  } vec_t;

  vec_t tbl [10];

  seg_scan_mux #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (D),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .load        (load),
    .blank_all   (blank_all),
    .seg_out     (seg_out),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (edge %0d): got seg=%h an=%b fs=%b, want seg=%h an=%b fs=%b",
               name, m_k, act[13:7], act[6:1], act[0], exp[13:7], exp[6:1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_k  = 0;
    m_pv = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = 7'h7F;
      m_pend[i]   = 7'h7F;
    end
    e_seg = 7'h7F;
    e_an  = '1;
    e_fs  = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [N*7-1:0] sin, input logic ba);
    int pos, slot, w;
    m_k++;
    pos  = m_k % P;
    slot = pos / S;
    w    = pos % S;
    if (ld) begin
      for (int i = 0; i < N; i++) m_pend[i] = sin[7*i +: 7];
      m_pv = 1'b1;
    end else if (pos == B && m_pv) begin
      for (int i = 0; i < N; i++) m_shadow[i] = m_pend[i];
      m_pv = 1'b0;
    end
    e_fs = (pos == B);
    e_an = '1;
    if (ba || w < B) begin
      e_seg = 7'h7F;
    end else begin
      e_an[slot] = 1'b0;
      e_seg      = m_shadow[slot];
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge(load, seg_in, blank_all);
    @(negedge clk);
    check(name, {seg_out, an_n, frame_start}, {e_seg, e_an, e_fs});
  endtask

  task automatic run(input int n, input string name);
    for (int i = 0; i < n; i++) step(name);
  endtask

  // Step until the next edge lands on frame position tgt.
  task automatic align_to(input int tgt, input string name);
    for (int i = 0; i < P && ((m_k + 1) % P) != tgt; i++) step(name);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < 10; i++) begin
      load      = tbl[i].ld;
      blank_all = tbl[i].ba;
      @(posedge clk);
      model_edge(load, seg_in, blank_all);
      @(negedge clk);
      check(name, {seg_out, an_n, frame_start}, {7'h7F, tbl[i].an, tbl[i].fs});
    end
    blank_all = 1'b0;
  endtask

  function automatic logic [N*7-1:0] pat(input logic [6:0] d0, input logic [6:0] d5);
    logic [N*7-1:0] v;
    v        = {N{7'h7F}};
    v[6:0]   = d0;
    v[35 +: 7] = d5;
    return v;
  endfunction

  initial begin
    logic [63:0] r;
    bit found;

    tbl[0] = '{1'b0, 1'b0, 6'h3F, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 6'h3E, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 6'h3E, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 6'h3F, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 6'h3E, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 6'h3F, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 6'h3F, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 6'h3D, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 6'h3D, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 6'h3D, 1'b0};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", {seg_out, an_n, frame_start}, {7'h7F, 6'h3F, 1'b0});
    reset = 1'b1;

    // Free run from reset.
    run_table("first_frame");
    run(2 * P - 10, "free_run");

    // Mid-frame load: old data persists until the next frame start.
    seg_in = pat(7'h01, 7'h12);
    load   = 1'b1;
    step("load_mid");
    load  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < P + 2 && !found; i++) begin
      step("wait_commit");
      found = (frame_start === 1'b1);
    end
    check("commit_glyph0", {seg_out, an_n, found}, {7'h01, 6'h3E, 1'b1});
    run(P, "after_commit");

    // Load landing on the commit cycle is deferred by one frame.
    align_to(B, "align_commit");
    seg_in = {N{7'h4F}};
    load   = 1'b1;
    step("commit_cycle_load");
    check("commit_cycle_old", {seg_out, an_n, frame_start}, {7'h01, 6'h3E, 1'b1});
    load = 1'b0;
    run(P + 4, "deferred_commit");

    // Two loads in one frame: only the second is ever shown.
    seg_in = pat(7'h06, 7'h4C);
    load   = 1'b1;
    step("load_a");
    load = 1'b0;
    run(3, "between_loads");
    seg_in = pat(7'h24, 7'h20);
    load   = 1'b1;
    step("load_b");
    load = 1'b0;
    run(2 * P, "only_b");

    // Blank-all mid-dwell of digit 3, then resume with remaining dwell.
    align_to(3 * S + B + 1, "align_d3");
    step("d3_drive");
    blank_all = 1'b1;
    run(10, "blank_all");
    blank_all = 1'b0;
    run(2 * P, "blank_release");

    // Asynchronous reset in the middle of digit 4.
    align_to(4 * S + B + 1, "align_d4");
    step("d4_drive");
    #2 reset = 1'b0;
    #1 check("async_reset", {seg_out, an_n, frame_start}, {7'h7F, 6'h3F, 1'b0});
    model_reset();
    @(negedge clk);
    check("reset_held", {seg_out, an_n, frame_start}, {7'h7F, 6'h3F, 1'b0});
    reset = 1'b1;
    run_table("restart_frame");
    run(P, "restart_run");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r         = {$urandom, $urandom};
      seg_in    = r[N*7-1:0];
      load      = ($urandom_range(7) == 0);
      blank_all = ($urandom_range(5) == 0);
      step("random");
    end
    load      = 1'b0;
    blank_all = 1'b0;
    run(P, "random_tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
